// File: rtl/timer_pkg.sv
// Shared definitions for the bus-mapped timer: register offsets, control bit
// positions and the address decode helper.
package timer_pkg;

  localparam logic [31:0] BASE_DEFAULT = 32'h0000_5000;

  localparam logic [31:0] OFF_CTRL   = 32'h0000_0000;
  localparam logic [31:0] OFF_PRESC  = 32'h0000_0004;
  localparam logic [31:0] OFF_COUNT  = 32'h0000_0008;
  localparam logic [31:0] OFF_CMP    = 32'h0000_000C;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0010;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  localparam logic [1:0]  MODE_READ  = 2'b01;
  localparam logic [1:0]  MODE_WRITE = 2'b10;
  localparam logic [31:0] CMP_RESET  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_CTRL   = 3'd1,
    SEL_PRESC  = 3'd2,
    SEL_COUNT  = 3'd3,
    SEL_CMP    = 3'd4,
    SEL_STATUS = 3'd5
  } reg_sel_e;

  function automatic reg_sel_e reg_decode(input logic [31:0] addr, input logic [31:0] base);
    reg_sel_e sel;
    if (addr == base + OFF_CTRL)        sel = SEL_CTRL;
    else if (addr == base + OFF_PRESC)  sel = SEL_PRESC;
    else if (addr == base + OFF_COUNT)  sel = SEL_COUNT;
    else if (addr == base + OFF_CMP)    sel = SEL_CMP;
    else if (addr == base + OFF_STATUS) sel = SEL_STATUS;
    else                                sel = SEL_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running divider: tick is asserted in the cycle where the running count
// equals the programmed divisor, giving one tick every presc+1 enabled cycles.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [15:0] presc,
  output logic        tick
);

  logic [15:0] presc_cnt_r;
  logic        tick_s;

  assign tick_s = enable && (presc_cnt_r == presc);
  assign tick   = tick_s;

  // Divider count: a clear from a CTRL/COUNT write restarts the period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_cnt_r <= 16'd0;
    end else if (clear) begin
      presc_cnt_r <= 16'd0;
    end else if (tick_s) begin
      presc_cnt_r <= 16'd0;
    end else if (enable) begin
      presc_cnt_r <= presc_cnt_r + 16'd1;
    end else begin
      presc_cnt_r <= presc_cnt_r;
    end
  end

endmodule

// File: rtl/timer_unit.sv
// Memory-mapped compare timer with prescaler, auto-reload/one-shot modes and
// a single-cycle active-low interrupt pulse on match.
module timer_unit
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE = BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] slv_address,
  input  logic [31:0] slv_write_data,
  input  logic [1:0]  slv_mode,
  input  logic        slv_select,
  output logic [31:0] slv_read_data,
  input  logic        ds_cpu_halt,
  output logic        irq_n
);

  logic [2:0]  ctrl_r;
  logic [15:0] presc_r;
  logic [31:0] count_r;
  logic [31:0] cmp_r;
  logic        mf_r;
  logic        irq_n_r;

  reg_sel_e    sel_s;
  logic        wr_s;
  logic        run_s;
  logic        presc_clr_s;
  logic        tick_s;
  logic        match_s;
  logic [31:0] read_data_s;

  assign sel_s       = reg_decode(slv_address, BASE);
  assign wr_s        = (slv_mode == MODE_WRITE) && slv_select;
  assign run_s       = ctrl_r[CTRL_EN] && !ds_cpu_halt;
  assign presc_clr_s = wr_s && ((sel_s == SEL_COUNT) || (sel_s == SEL_CTRL));
  assign match_s     = tick_s && (count_r == cmp_r);

  timer_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (run_s),
    .clear  (presc_clr_s),
    .presc  (presc_r),
    .tick   (tick_s)
  );

  // Register file and counter; bus writes take priority over match updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_r  <= 3'd0;
      presc_r <= 16'd0;
      count_r <= 32'd0;
      cmp_r   <= CMP_RESET;
      mf_r    <= 1'b0;
      irq_n_r <= 1'b1;
    end else begin
      if (wr_s && (sel_s == SEL_CTRL)) begin
        ctrl_r <= slv_write_data[2:0];
      end else if (match_s && !ctrl_r[CTRL_AUTO]) begin
        ctrl_r[CTRL_EN] <= 1'b0;
      end else begin
        ctrl_r <= ctrl_r;
      end

      if (wr_s && (sel_s == SEL_PRESC)) begin
        presc_r <= slv_write_data[15:0];
      end else begin
        presc_r <= presc_r;
      end

      if (wr_s && (sel_s == SEL_CMP)) begin
        cmp_r <= slv_write_data;
      end else begin
        cmp_r <= cmp_r;
      end

      if (wr_s && (sel_s == SEL_COUNT)) begin
        count_r <= slv_write_data;
      end else if (match_s) begin
        count_r <= ctrl_r[CTRL_AUTO] ? 32'd0 : count_r;
      end else if (tick_s) begin
        count_r <= count_r + 32'd1;
      end else begin
        count_r <= count_r;
      end

      // A match in the same cycle as a write-1-clear keeps the flag set.
      if (match_s) begin
        mf_r <= 1'b1;
      end else if (wr_s && (sel_s == SEL_STATUS) && slv_write_data[0]) begin
        mf_r <= 1'b0;
      end else begin
        mf_r <= mf_r;
      end

      irq_n_r <= ~(match_s && ctrl_r[CTRL_IE]);
    end
  end

  // Read mux, ungated by select or mode.
  always_comb begin
    read_data_s = 32'd0;
    case (sel_s)
      SEL_CTRL:   read_data_s = {29'd0, ctrl_r};
      SEL_PRESC:  read_data_s = {16'd0, presc_r};
      SEL_COUNT:  read_data_s = count_r;
      SEL_CMP:    read_data_s = cmp_r;
      SEL_STATUS: read_data_s = {31'd0, mf_r};
      default:    read_data_s = 32'd0;
    endcase
  end

  assign slv_read_data = read_data_s;
  assign irq_n         = irq_n_r;

endmodule

// File: tb/tb_timer_unit.sv
// Directed self-checking bench for timer_unit: reset values, auto-reload,
// one-shot, W1C race, wrap, debug halt and asynchronous reset during irq.
module tb_timer_unit;

  localparam logic [31:0] BASE = 32'h0000_5000;
  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_PRESC  = 32'h4;
  localparam logic [31:0] A_COUNT  = 32'h8;
  localparam logic [31:0] A_CMP    = 32'hC;
  localparam logic [31:0] A_STATUS = 32'h10;

  logic        clk;
  logic        reset;
  logic [31:0] slv_address;
  logic [31:0] slv_write_data;
  logic [1:0]  slv_mode;
  logic        slv_select;
  logic [31:0] slv_read_data;
  logic        ds_cpu_halt;
  logic        irq_n;

  int n_cmp;
  int n_err;

  timer_unit #(.BASE(BASE)) dut (
    .clk            (clk),
    .reset          (reset),
    .slv_address    (slv_address),
    .slv_write_data (slv_write_data),
    .slv_mode       (slv_mode),
    .slv_select     (slv_select),
    .slv_read_data  (slv_read_data),
    .ds_cpu_halt    (ds_cpu_halt),
    .irq_n          (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] off, input logic [31:0] exp);
    slv_address = BASE + off;
    #1;
    chk(tag, slv_read_data, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'd0, irq_n}, {31'd0, exp});
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
    @(negedge clk);
    slv_address    = BASE + off;
    slv_write_data = data;
    slv_mode       = 2'b10;
    slv_select     = 1'b1;
    @(posedge clk);
    #1;
    slv_mode   = 2'b00;
    slv_select = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    slv_address = 32'd0;
    slv_write_data = 32'd0;
    slv_mode = 2'b00;
    slv_select = 1'b0;
    ds_cpu_halt = 1'b0;

    // Reset values
    #12;
    chk_reg("rst_ctrl", A_CTRL, 32'd0);
    chk_reg("rst_presc", A_PRESC, 32'd0);
    chk_reg("rst_count", A_COUNT, 32'd0);
    chk_reg("rst_cmp", A_CMP, 32'hFFFF_FFFF);
    chk_reg("rst_status", A_STATUS, 32'd0);
    chk_irq("rst_irq", 1'b1);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_reg("idle_count", A_COUNT, 32'd0);

    // Register access: PRESC is 16 bits, unmapped offset reads zero
    bus_write(A_PRESC, 32'h1234_ABCD);
    chk_reg("presc_rb", A_PRESC, 32'h0000_ABCD);
    chk_reg("unmapped", 32'h14, 32'd0);
    bus_write(A_PRESC, 32'd0);

    // Auto-reload with irq: COUNT 1,2,3,0 repeating
    bus_write(A_CMP, 32'd3);
    bus_write(A_COUNT, 32'd0);
    bus_write(A_CTRL, 32'd7);
    chk_reg("auto_c0", A_COUNT, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_reg($sformatf("auto_count_%0d", k), A_COUNT, k % 4);
      chk_irq($sformatf("auto_irq_%0d", k), (k % 4) != 0);
      chk_reg($sformatf("auto_mf_%0d", k), A_STATUS, (k >= 4) ? 32'd1 : 32'd0);
    end
    bus_write(A_CTRL, 32'd0);

    // W1C racing a match keeps MF; a later clear works
    bus_write(A_COUNT, 32'd0);
    bus_write(A_CTRL, 32'd3);
    step();
    step();
    step();
    chk_reg("race_pre", A_COUNT, 32'd3);
    bus_write(A_STATUS, 32'd1);
    chk_reg("race_mf", A_STATUS, 32'd1);
    chk_reg("race_count", A_COUNT, 32'd0);
    chk_irq("race_noirq", 1'b1);
    bus_write(A_CTRL, 32'd0);
    bus_write(A_STATUS, 32'd1);
    chk_reg("w1c_mf", A_STATUS, 32'd0);

    // One-shot, PRESC=2, CMP=1: match on 6th edge after enable
    bus_write(A_COUNT, 32'd0);
    bus_write(A_CMP, 32'd1);
    bus_write(A_PRESC, 32'd2);
    bus_write(A_CTRL, 32'd5);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_reg($sformatf("os_count_%0d", k), A_COUNT, (k >= 3) ? 32'd1 : 32'd0);
      chk_irq($sformatf("os_irq_%0d", k), k != 6);
    end
    chk_reg("os_ctrl", A_CTRL, 32'd4);
    chk_reg("os_mf", A_STATUS, 32'd1);

    // Wrap past 0xFFFFFFFF sets nothing
    bus_write(A_CTRL, 32'd0);
    bus_write(A_STATUS, 32'd1);
    bus_write(A_PRESC, 32'd0);
    bus_write(A_CMP, 32'd5);
    bus_write(A_COUNT, 32'hFFFF_FFFE);
    bus_write(A_CTRL, 32'd7);
    step();
    chk_reg("wrap_1", A_COUNT, 32'hFFFF_FFFF);
    step();
    chk_reg("wrap_2", A_COUNT, 32'd0);
    chk_irq("wrap_irq", 1'b1);
    step();
    chk_reg("wrap_3", A_COUNT, 32'd1);
    chk_reg("wrap_mf", A_STATUS, 32'd0);
    chk_irq("wrap_irq2", 1'b1);
    bus_write(A_CTRL, 32'd0);

    // Debug halt freezes COUNT, bus still writable (CMP below COUNT: no match)
    bus_write(A_COUNT, 32'h100);
    bus_write(A_CTRL, 32'd3);
    step();
    chk_reg("halt_run1", A_COUNT, 32'h101);
    step();
    chk_reg("halt_run2", A_COUNT, 32'h102);
    ds_cpu_halt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_reg($sformatf("halt_a_%0d", k), A_COUNT, 32'h102);
    end
    bus_write(A_CMP, 32'h110);
    chk_reg("halt_cmp", A_CMP, 32'h110);
    chk_reg("halt_wr", A_COUNT, 32'h102);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_reg($sformatf("halt_b_%0d", k), A_COUNT, 32'h102);
    end
    ds_cpu_halt = 1'b0;
    step();
    chk_reg("halt_resume", A_COUNT, 32'h103);
    chk_reg("halt_ctrl", A_CTRL, 32'd3);

    // Asynchronous reset during irq pulse
    bus_write(A_CTRL, 32'd0);
    bus_write(A_COUNT, 32'd0);
    bus_write(A_CMP, 32'd1);
    bus_write(A_CTRL, 32'd7);
    step();
    chk_reg("ar_c1", A_COUNT, 32'd1);
    step();
    chk_irq("ar_irq_low", 1'b0);
    reset = 1'b0;
    #1;
    chk_irq("ar_irq", 1'b1);
    chk_reg("ar_ctrl", A_CTRL, 32'd0);
    chk_reg("ar_count", A_COUNT, 32'd0);
    chk_reg("ar_cmp", A_CMP, 32'hFFFF_FFFF);
    chk_reg("ar_status", A_STATUS, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_reg("ar_post", A_COUNT, 32'd0);
    chk_irq("ar_post_irq", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
